pwm_rgbw_generator: RTL and testbench
=====================================

Name: pwm_rgbw_generator

Overview:
- Four-channel (R, G, B, W) PWM generator placed directly downstream of the PWM clock prescaler.
- Consumes the prescaler's `clkPresc` level as a sampled signal in the `clk` domain and advances a shared period counter once per rising edge.
- Drives four PWM outputs from double-buffered duty values.
- New duty sets arrive over a valid/ready handshake and take effect only at a period boundary, so the LEDs never glitch.

Parameters:
- WIDTH, 8, bit width of duty values and period counter. Period = 2^WIDTH-1 ticks.

Ports:
- clk  input  1  system clock; the only clock domain.
- reset  input  1  asynchronous, active-low reset.
- clkPresc  input  1  prescaler output level, synchronous to clk; rising edges are ticks.
- dutyR  input  WIDTH  red duty request.
- dutyG  input  WIDTH  green duty request.
- dutyB  input  WIDTH  blue duty request.
- dutyW  input  WIDTH  white duty request.
- dutyValid  input  1  duty set offered this cycle.
- dutyReady  output  1  block can accept a duty set.
- pwmR  output  1  red PWM output.
- pwmG  output  1  green PWM output.
- pwmB  output  1  blue PWM output.
- pwmW  output  1  white PWM output.
- periodStart  output  1  one-clk pulse when the counter wraps to 0.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low (reset==0). Assertion takes effect immediately, not on a clk edge.
  - Values while in reset: cnt=0, prevPresc=0, pending regs=0, active regs=0, pendFlag=0, all pwm*=0, periodStart=0, dutyReady=1.
  - Reset asserted mid-period aborts that period. Any pending set is lost.
- Tick:
  - prevPresc <= clkPresc every clk.
  - tick = clkPresc & ~prevPresc, a one-clk pulse.
  - With the standard prescaler this gives one tick every 4 clk. The block must not depend on that ratio.
- Counter:
  - cnt counts 0 .. 2^WIDTH-2 and increments only on tick.
  - On a tick with cnt==2^WIDTH-2, cnt wraps to 0. This is the "wrap" event.
  - periodStart <= wrap, registered, so the pulse is high in the same cycle cnt reads 0.
- Handshake (FSM on pendFlag):
  - States: IDLE (pendFlag=0) and PENDING (pendFlag=1).
  - dutyReady = ~pendFlag, combinational from the flag.
  - IDLE -> PENDING when dutyValid & dutyReady. All four duty inputs are captured into the pending regs that cycle.
  - PENDING -> IDLE on wrap. The active regs load from the pending regs.
  - In PENDING, dutyValid is ignored; the upstream block must hold its data.
  - Simultaneous events, handshake in IDLE on a wrap cycle: the set is captured into pending and applied at the NEXT wrap, never the current one.
  - Wrap while in IDLE leaves the active regs unchanged.
- Output:
  - pwmX <= (cnt < activeX), registered. pwm* therefore lag cnt by one clk.
  - duty 0 gives a constantly low output.
  - duty 2^WIDTH-1 (255 at default) gives a constantly high output, with no dropout at wrap.
  - duty N gives high for exactly N ticks per period.
- Arithmetic: unsigned, WIDTH bits; compare without extension. Counter never reaches 2^WIDTH-1.

Decomposition:
- Shared package holds:
  - PWM_WIDTH = 8.
  - PWM_CNT_MAX = 2^PWM_WIDTH-2.
  - Handshake state encoding: IDLE=0, PENDING=1.
- Sub-module pwm_tick_detect: registers clkPresc and emits the rising-edge tick. It is reused by other prescaler consumers.
- Per-channel compare stays inline, as four identical always-blocks or a generate loop.

Test Plan:
- Reset: assert reset low asynchronously between clk edges mid-run -> all pwm*=0, periodStart=0, dutyReady=1 immediately, with no clk edge needed. Release -> cnt starts at 0 on the first tick.
- Basic duty: load R=128, G=0, B=255, W=1 with prescaler toggling every 2 clk. After the first wrap:
  - pwmR high 512 clk out of a 1020 clk period.
  - pwmG never high.
  - pwmB never low.
  - pwmW high exactly 4 clk, starting one clk after periodStart.
- Double-buffer: load R=10. Mid-period, load R=200 -> dutyReady drops to 0 for the rest of the period. pwmR keeps the 10-tick width until wrap, then switches to 200 ticks. dutyReady returns to 1 the cycle after wrap.
- Backpressure: hold dutyValid=1 with changing data while dutyReady=0 -> pending regs unchanged. Only the data present in the accept cycle is applied.
- Simultaneous: assert dutyValid in the exact wrap cycle with R=50 while active R=20 -> the period following that wrap uses 20. The next period uses 50.
- Tick robustness: hold clkPresc high for 20 clk, then low -> cnt advances exactly once. Toggling clkPresc every clk gives a tick every 2 clk, and the period becomes 510 clk.

Source files
------------

// File: rtl/pwm_rgbw_generator_pkg.sv
// Shared definitions for the RGBW PWM generator and its prescaler-side helpers.
package pwm_rgbw_generator_pkg;

    localparam int unsigned PWM_WIDTH    = 8;
    localparam int unsigned PWM_CNT_MAX  = 2**PWM_WIDTH - 2;
    localparam int unsigned PWM_CHANNELS = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } hs_state_t;

endpackage

// File: rtl/pwm_tick_detect.sv
// Turns the prescaler output level into a one-clk tick on each of its rising edges.
module pwm_tick_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_presc,
    output logic o_tick
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_presc;
        end
    end

    assign o_tick = i_presc & ~r_prev;

endmodule

// File: rtl/pwm_rgbw_generator.sv
// Four-channel PWM with double-buffered duty values; new sets only take effect at a period wrap.
module pwm_rgbw_generator
    import pwm_rgbw_generator_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkPresc,
    input  logic [WIDTH-1:0] dutyR,
    input  logic [WIDTH-1:0] dutyG,
    input  logic [WIDTH-1:0] dutyB,
    input  logic [WIDTH-1:0] dutyW,
    input  logic             dutyValid,
    output logic             dutyReady,
    output logic             pwmR,
    output logic             pwmG,
    output logic             pwmB,
    output logic             pwmW,
    output logic             periodStart
);

    // Counter stops one short of all-ones so a full-scale duty never drops out.
    localparam logic [WIDTH-1:0] CNT_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_accept;
    logic [WIDTH-1:0]        r_cnt;
    logic                    r_period_start;
    hs_state_t               r_state;
    hs_state_t               w_state_next;
    logic [WIDTH-1:0]        w_duty   [PWM_CHANNELS];
    logic [WIDTH-1:0]        r_pend   [PWM_CHANNELS];
    logic [WIDTH-1:0]        r_active [PWM_CHANNELS];
    logic [PWM_CHANNELS-1:0] r_pwm;

    assign w_duty[0] = dutyR;
    assign w_duty[1] = dutyG;
    assign w_duty[2] = dutyB;
    assign w_duty[3] = dutyW;

    pwm_tick_detect u_tick (
        .clk     (clk),
        .rst_n   (reset),
        .i_presc (clkPresc),
        .o_tick  (w_tick)
    );

    assign w_wrap = w_tick && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
            if (w_tick) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An accept on a wrap cycle only moves into PENDING; the set waits for the next wrap.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        dutyReady    = (r_state == IDLE);
        case (r_state)
            IDLE: begin
                if (dutyValid) begin
                    w_accept     = 1'b1;
                    w_state_next = PENDING;
                end
            end
            PENDING: begin
                if (w_wrap) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < PWM_CHANNELS; c++) begin
                r_pend[c]   <= '0;
                r_active[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < PWM_CHANNELS; c++) begin
                if (w_accept) begin
                    r_pend[c] <= w_duty[c];
                end
                if ((r_state == PENDING) && w_wrap) begin
                    r_active[c] <= r_pend[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm <= '0;
        end else begin
            for (int unsigned c = 0; c < PWM_CHANNELS; c++) begin
                r_pwm[c] <= (r_cnt < r_active[c]);
            end
        end
    end

    assign pwmR        = r_pwm[0];
    assign pwmG        = r_pwm[1];
    assign pwmB        = r_pwm[2];
    assign pwmW        = r_pwm[3];
    assign periodStart = r_period_start;

endmodule

// File: tb/tb_pwm_rgbw_generator.sv
// Bench for pwm_rgbw_generator: tick-level reference model plus directed period measurements.
module tb_pwm_rgbw_generator;

    localparam int W   = 8;
    localparam int PER = 255;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clkPresc = 1'b0;
    logic [W-1:0] dR = '0, dG = '0, dB = '0, dW = '0;
    logic         dutyValid = 1'b0;
    logic         dutyReady, pwmR, pwmG, pwmB, pwmW, periodStart;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_rgbw_generator #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .clkPresc    (clkPresc),
        .dutyR       (dR),
        .dutyG       (dG),
        .dutyB       (dB),
        .dutyW       (dW),
        .dutyValid   (dutyValid),
        .dutyReady   (dutyReady),
        .pwmR        (pwmR),
        .pwmG        (pwmG),
        .pwmB        (pwmB),
        .pwmW        (pwmW),
        .periodStart (periodStart)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Prescaler stand-in: 0 low, 1 toggle every 2 clk, 2 toggle every clk, 3 high, 4 random.
    int pmode = 0;
    int pdiv  = 0;
    always @(negedge clk) begin
        pdiv++;
        case (pmode)
            1:       clkPresc = ((pdiv / 2) % 2) == 1;
            2:       clkPresc = ~clkPresc;
            3:       clkPresc = 1'b1;
            4:       clkPresc = ($urandom % 2) == 1;
            default: clkPresc = 1'b0;
        endcase
    end

    // Reference model: position in period, active set and at most one waiting set.
    int m_cnt;
    bit m_prev;
    int m_active [4];
    int m_pend   [4];
    bit m_has;
    bit e_pwm    [4];
    bit e_ps;
    bit e_ready;

    always @(posedge clk or negedge reset) begin
        bit tick, wrap, acc;
        int din [4];
        if (!reset) begin
            m_cnt  = 0;
            m_prev = 0;
            m_has  = 0;
            for (int c = 0; c < 4; c++) begin
                m_active[c] = 0;
                m_pend[c]   = 0;
                e_pwm[c]    = 0;
            end
            e_ps    = 0;
            e_ready = 1;
        end else begin
            din[0] = dR; din[1] = dG; din[2] = dB; din[3] = dW;
            tick   = clkPresc && !m_prev;
            m_prev = clkPresc;
            wrap   = tick && (m_cnt == PER - 1);
            acc    = !m_has && dutyValid;
            for (int c = 0; c < 4; c++) e_pwm[c] = (m_cnt < m_active[c]);
            e_ps = wrap;
            if (wrap && m_has) begin
                m_active = m_pend;
                m_has    = 0;
            end
            if (acc) begin
                m_pend = din;
                m_has  = 1;
            end
            if (tick) m_cnt = (m_cnt + 1) % PER;
            e_ready = !m_has;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("pwmR", pwmR, e_pwm[0]);
        chk("pwmG", pwmG, e_pwm[1]);
        chk("pwmB", pwmB, e_pwm[2]);
        chk("pwmW", pwmW, e_pwm[3]);
        chk("periodStart", periodStart, e_ps);
        chk("dutyReady", dutyReady, e_ready);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int r, input int g, input int b, input int w);
        int t = 0;
        while (dutyReady !== 1'b1 && t < 3000) begin
            cyc();
            t++;
        end
        chk("load_wait_bound", int'(t < 3000), 1);
        dR = W'(r); dG = W'(g); dB = W'(b); dW = W'(w);
        dutyValid = 1'b1;
        cyc();
        dutyValid = 1'b0;
    endtask

    task automatic wait_ps();
        int t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!periodStart && t < 4000);
        chk("periodStart_wait_bound", int'(t < 4000), 1);
    endtask

    // Window: cycle after a periodStart through the next periodStart inclusive.
    task automatic window(output int hi [4], output int plen, output int wfirst, output int rdy);
        rdy    = dutyReady;
        plen   = 0;
        wfirst = -1;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        do begin
            @(posedge clk);
            #1;
            plen++;
            hi[0] += int'(pwmR);
            hi[1] += int'(pwmG);
            hi[2] += int'(pwmB);
            hi[3] += int'(pwmW);
            if (pwmW && wfirst < 0) wfirst = plen;
        end while (!periodStart && plen < 4000);
    endtask

    task automatic measure(output int hi [4], output int plen, output int wfirst, output int rdy);
        wait_ps();
        window(hi, plen, wfirst, rdy);
    endtask

    initial begin
        int hi [4];
        int plen, wfirst, rdy, t;

        repeat (3) cyc();
        chk("reset_pwmR", pwmR, 0);
        chk("reset_pwmB", pwmB, 0);
        chk("reset_periodStart", periodStart, 0);
        chk("reset_dutyReady", dutyReady, 1);
        reset = 1'b1;
        pmode = 1;

        load(128, 0, 255, 1);
        measure(hi, plen, wfirst, rdy);
        chk("basic_period_clk", plen, 1020);
        chk("basic_R_high", hi[0], 512);
        chk("basic_G_high", hi[1], 0);
        chk("basic_B_high", hi[2], 1020);
        chk("basic_W_high", hi[3], 4);
        chk("basic_W_first", wfirst, 1);

        cyc();
        load(10, 0, 0, 0);
        measure(hi, plen, wfirst, rdy);
        chk("dbuf_R10_high", hi[0], 40);
        repeat (400) cyc();
        load(200, 0, 0, 0);
        chk("dbuf_ready_drop", dutyReady, 0);
        repeat (50) begin
            dR = W'($urandom); dG = W'($urandom); dB = W'($urandom); dW = W'($urandom);
            dutyValid = 1'b1;
            cyc();
            chk("bp_ready_low", dutyReady, 0);
        end
        dutyValid = 1'b0;
        measure(hi, plen, wfirst, rdy);
        chk("dbuf_ready_after_wrap", rdy, 1);
        chk("dbuf_R200_high", hi[0], 800);
        chk("bp_G_high", hi[1], 0);
        chk("bp_B_high", hi[2], 0);
        chk("bp_W_high", hi[3], 0);

        cyc();
        load(20, 0, 0, 0);
        measure(hi, plen, wfirst, rdy);
        chk("sim_R20_applied", hi[0], 80);
        cyc();
        t = 0;
        while (!(m_cnt == PER - 1 && clkPresc && !m_prev && dutyReady) && t < 3000) begin
            cyc();
            t++;
        end
        chk("sim_wrap_search_bound", int'(t < 3000), 1);
        dR = 8'd50;
        dutyValid = 1'b1;
        @(posedge clk);
        #1;
        dutyValid = 1'b0;
        chk("sim_wrap_hit", periodStart, 1);
        window(hi, plen, wfirst, rdy);
        chk("sim_next_period_R20", hi[0], 80);
        window(hi, plen, wfirst, rdy);
        chk("sim_following_R50", hi[0], 200);

        cyc();
        pmode = 0;
        repeat (10) cyc();
        pmode = 3;
        repeat (20) cyc();
        pmode = 0;
        repeat (20) cyc();
        pmode = 2;
        measure(hi, plen, wfirst, rdy);
        chk("fast_period_clk", plen, 510);
        chk("fast_R50_high", hi[0], 100);

        cyc();
        pmode = 4;
        repeat (3000) begin
            int sel;
            logic [W-1:0] v [4];
            for (int c = 0; c < 4; c++) begin
                sel = $urandom_range(0, 4);
                v[c] = (sel == 0) ? W'(0) : (sel == 1) ? W'(255) : (sel == 2) ? W'(1) : W'($urandom);
            end
            dR = v[0]; dG = v[1]; dB = v[2]; dW = v[3];
            dutyValid = ($urandom % 6) == 0;
            cyc();
        end
        dutyValid = 1'b0;

        pmode = 1;
        load(255, 255, 255, 255);
        repeat (5) cyc();
        load(77, 77, 77, 77);
        repeat (5) cyc();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_pwmR", pwmR, 0);
        chk("async_pwmW", pwmW, 0);
        chk("async_periodStart", periodStart, 0);
        chk("async_dutyReady", dutyReady, 1);
        repeat (3) cyc();
        reset = 1'b1;
        measure(hi, plen, wfirst, rdy);
        chk("reset_pending_lost_R", hi[0], 0);
        chk("reset_pending_lost_W", hi[3], 0);
        chk("reset_period_clk", plen, 1020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
